// File: rtl/pcm_frame_mixer.sv
// pcm_frame_mixer: buffers one PCM sample per channel and averages the enabled channels
// once per sample tick. Define PCM_FRAME_MIXER_GAIN_EN to add a saturating 2-bit output gain.
module pcm_frame_mixer #(
   parameter int NUM_CH  = 8,
   parameter int CLK_DIV = 6250
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_CH*8-1:0] in_pcm,
   input  logic [NUM_CH-1:0]   in_vld,
   output logic [NUM_CH-1:0]   in_rdy,
   input  logic [NUM_CH-1:0]   ch_en,
`ifdef PCM_FRAME_MIXER_GAIN_EN
   input  logic [1:0]          gain,
`endif
   output logic [7:0]          out_sample,
   output logic                out_strobe
);
   localparam int LOG2_CH = $clog2(NUM_CH);
   localparam int SUM_W   = 8 + LOG2_CH;
   localparam int CNT_W   = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0]   div_cnt_reg;
   logic               tick;
   logic [7:0]         hold_next [NUM_CH];
   logic [7:0]         term      [NUM_CH];
   logic [SUM_W-1:0]   sum_next;
   logic [7:0]         mix;
   logic [LOG2_CH-1:0] sum_frac_unused;
   logic [7:0]         out_next;
   logic [7:0]         out_sample_reg;
   logic               out_strobe_reg;

   assign tick = (div_cnt_reg == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         div_cnt_reg <= '0;
      else if (tick)
         div_cnt_reg <= '0;
      else
         div_cnt_reg <= div_cnt_reg + CNT_W'(1);
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [7:0] slot_reg;
      logic [7:0] hold_reg;
      logic       slot_full_reg;
      logic       take;

      // Only a sample that was already waiting moves to hold; one arriving on the tick waits a frame.
      assign take = tick & slot_full_reg;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            slot_reg      <= 8'h00;
            hold_reg      <= 8'h80;
            slot_full_reg <= 1'b0;
         end else if (take) begin
            hold_reg      <= slot_reg;
            slot_full_reg <= 1'b0;
         end else if (in_vld[gi] & in_rdy[gi]) begin
            slot_reg      <= in_pcm[8*gi +: 8];
            slot_full_reg <= 1'b1;
         end
      end

      assign in_rdy[gi]    = rst_n & ~slot_full_reg;
      assign hold_next[gi] = take ? slot_reg : hold_reg;
      assign term[gi]      = ch_en[gi] ? hold_next[gi] : 8'h80;
   end

   always_comb begin
      sum_next = '0;
      for (int i = 0; i < NUM_CH; i++)
         sum_next = sum_next + SUM_W'(term[i]);
   end

   assign {mix, sum_frac_unused} = sum_next;

`ifdef PCM_FRAME_MIXER_GAIN_EN
   logic signed [8:0]  centred;
   logic signed [11:0] gained;
   logic [7:0]         clamped;

   // Work around the 0x80 midpoint so the shift scales symmetrically, then saturate.
   always_comb begin
      centred = $signed({1'b0, mix}) - 9'sd128;
      gained  = $signed({{3{centred[8]}}, centred}) <<< gain;
      if (gained > 12'sd127)
         clamped = 8'h7F;
      else if (gained < -12'sd128)
         clamped = 8'h80;
      else
         clamped = gained[7:0];
      out_next = clamped + 8'h80;
   end
`else
   assign out_next = mix;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_sample_reg <= 8'h80;
         out_strobe_reg <= 1'b0;
      end else begin
         out_strobe_reg <= tick;
         if (tick)
            out_sample_reg <= out_next;
      end
   end

   assign out_sample = out_sample_reg;
   assign out_strobe = out_strobe_reg;

endmodule

// File: doc/pcm_frame_mixer.md
Name: pcm_frame_mixer

Overview:
- Downstream consumer of the bytebeat generator PCM streams.
- Accepts NUM_CH 8-bit PCM channels over valid/ready handshakes and holds one pending sample per channel.
- On each internally generated sample-rate tick, mixes the enabled channels into one 8-bit unsigned sample.
- Drives that sample to a single pwm_audio instance, together with a one-cycle strobe.

Parameters:
- NUM_CH, 8: number of input channels; must be a power of two, 2..16.
- CLK_DIV, 6250: clocks per output sample (50 MHz / 8 kHz); must be >= 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- in_pcm  input  NUM_CH*8  channel i sample on bits [8i+7:8i], unsigned, 0x80 = silence.
- in_vld  input  NUM_CH  per-channel sample valid.
- in_rdy  output  NUM_CH  per-channel ready.
- ch_en  input  NUM_CH  per-channel mix enable; sampled only on tick cycles.
- out_sample  output  8  mixed sample, unsigned, registered.
- out_strobe  output  1  one-cycle pulse when out_sample updates.

Behaviour:
- Clocking and reset: one clock, clk; reset rst_n is asynchronous, active-low. Async assert clears all state immediately, including mid-frame.
- Reset values:
  - div counter = 0.
  - every slot_full = 0.
  - every hold register = 0x80.
  - out_sample = 0x80, out_strobe = 0.
  - in_rdy = 0 while rst_n is low.
- Tick generation:
  - Counter runs 0..CLK_DIV-1 and wraps to 0.
  - tick = 1 in the cycle where counter == CLK_DIV-1.
  - First tick occurs in the CLK_DIV-th cycle after reset release.
- Per-channel slot:
  - in_rdy[i] = rst_n & !slot_full[i] (combinational from a register only).
  - Handshake when in_vld[i] & in_rdy[i]: slot <= in_pcm bits, slot_full <= 1.
- Tick, per channel:
  - If slot_full[i] was already 1 before this cycle: hold[i] <= slot[i] and slot_full[i] <= 0.
  - Otherwise hold[i] is unchanged (last sample repeats; underrun is silent-safe).
- Simultaneous handshake and tick on an empty slot:
  - The mix uses the old hold[i].
  - The new sample lands in the slot (slot_full = 1) and is consumed on the next tick.
- Back-pressure: a full slot deasserts in_rdy until the next tick. At most one sample per channel per frame; excess producers stall.
- Mix, computed on tick from the values being written to hold (post-update):
  - term_i = ch_en[i] ? hold_new[i] : 0x80.
  - sum = sum of all term_i, width 8 + log2(NUM_CH), no overflow possible.
  - mix = sum >> log2(NUM_CH), i.e. an exact average with truncation.
- Output timing:
  - out_sample <= mix, registered in the tick cycle; visible the cycle after tick.
  - out_strobe = 1 in that same cycle only; otherwise 0.
  - Latency: sample accepted before tick N appears on out_sample 1 cycle after tick N.
- All channels disabled: out_sample = 0x80 exactly.

Optional Feature:
- Macro: PCM_FRAME_MIXER_GAIN_EN.
- Defined:
  - Adds input port gain, width 2.
  - Centred value c = mix - 128 (signed 9-bit).
  - g = c <<< gain.
  - Clamp g to [-128, 127].
  - out_sample = g + 128.
  - gain is sampled on tick.
- Not defined: no gain port; out_sample = mix unchanged.

Test Plan (NUM_CH=8, CLK_DIV=4 unless noted):
1. Reset release, no inputs -> in_rdy=0xFF; out_strobe pulses every 4 cycles starting cycle 4 after release; out_sample stays 0x80.
2. Ch0 sends 0xFF, ch_en=0x01, others idle -> sum = 0xFF + 7*0x80 = 1151; out_sample = 143 (0x8F) after the first tick; in_rdy[0]=0 from handshake until tick.
3. Ch0 offers two samples 0x10 then 0x20 within one frame -> second stalls (in_rdy[0]=0); first frame mixes 0x10, next frame 0x20; no sample lost.
4. All 8 channels send 0x00, ch_en=0xFF -> out_sample=0x00; then ch_en=0x00 at the next tick -> 0x80.
5. Handshake on ch3 exactly on a tick cycle with 0x40 while hold=0x80 -> that tick mixes 0x80; the following tick mixes 0x40.
6. Assert rst_n low mid-frame with slots full -> out_sample=0x80, out_strobe=0, in_rdy=0 immediately; after release the counter restarts and prior slot data is discarded. With PCM_FRAME_MIXER_GAIN_EN, gain=3 and all channels 0xFF -> out_sample=0xFF (clamped).
